mod_reg16_4to16: RTL and testbench
==================================

Name: mod_reg16_4to16

Overview:
- Downstream of the 1-to-4 byte collector. Accepts 32-bit AES words (4 bytes, one column) on a valid/ready handshake and assembles Nb words into one 128-bit AES state block.
- Presents each completed block to the round datapath on a valid/ready handshake.
- Ping-pong double buffer: one block is filled while the previous one waits to be consumed.

Parameters:
- Nb, 4, words (columns) per state block; the counter width and output width derive from it.
- WW, 32, word width in bits (4 bytes).

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-high reset (asserted = 1). The name is kept for codebase uniformity.
- in_valid  in  1  in_word holds a valid column.
- in_ready  out  1  block can accept a word this cycle.
- in_word  in  WW  column word; byte k = in_word[8k+7:8k] (byte 0 = first byte collected upstream).
- flush  in  1  discard the partially filled block.
- out_valid  out  1  out_state holds a complete block.
- out_ready  in  1  consumer takes the block this cycle.
- out_state  out  Nb*WW  column c = out_state[WW*c+WW-1:WW*c].
- fill_cnt  out  2  words already stored in the current write buffer (0..Nb-1).
- full_cnt  out  2  number of complete buffers pending (0..2).

Behaviour:
- Storage: buf[0..1], each Nb*WW bits, with a per-buffer flag bfull[b]. Pointers: wptr (buffer being filled), rptr (buffer being presented), wcnt (next column index).
- Reset (resetn=1 at a clk edge), results visible after that edge:
  - all buffers zero, bfull = 0, wptr = rptr = 0, wcnt = 0.
  - out_valid = 0, out_state = 0, fill_cnt = 0, full_cnt = 0.
  - in_ready = 0 while resetn = 1; it is 1 in the first cycle after deassertion.
  - Reset mid-block discards all partial and complete data.
- in_ready = !bfull[wptr] && !flush && !resetn. It depends on registered state and flush only; there is no combinational path from out_ready.
- Write accept (in_valid && in_ready):
  - buf[wptr] column wcnt <= in_word.
  - If wcnt == Nb-1: bfull[wptr] <= 1, wptr toggles, wcnt <= 0.
  - Otherwise wcnt increments.
- Output:
  - out_valid = bfull[rptr]; out_state = buf[rptr], combinational from registers.
  - Read accept (out_valid && out_ready): bfull[rptr] <= 0, rptr toggles. Buffer contents are not cleared.
  - While out_valid && !out_ready, out_state and out_valid hold stable.
- Latency: the word completing a block is accepted at edge N; out_valid = 1 from edge N onward (first cycle after N).
- Throughput: 1 word/cycle sustained with out_ready held high. One block per Nb cycles, with no bubbles.
- Simultaneous events:
  - A read of buffer rptr and a write completing the other buffer in the same cycle both take effect.
  - A write into a buffer is never permitted while it is bfull, so the same buffer is never read and written at once.
- Both buffers full: in_ready = 0 until a read accept. The first free cycle after that read accept is the cycle following it.
- flush at a clk edge:
  - wcnt <= 0, buf[wptr] <= 0, and any word presented that cycle is dropped (in_ready is already 0).
  - Full buffers, rptr and out_valid are unaffected.
  - flush with wcnt == 0 is a no-op.
- fill_cnt = wcnt. full_cnt = bfull[0] + bfull[1].
- Wrap-around: the wcnt and wptr/rptr toggles wrap naturally. No overflow or underflow is possible under the handshake rules.

Test Plan:
- Reset, then send words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles with out_ready=1 -> out_valid for exactly 1 cycle, starting the cycle after the 4th accept. out_state = 0x0F0E0D0C_0B0A0908_07060504_03020100. full_cnt returns to 0.
- out_ready=0, stream 12 words back-to-back -> 8 words accepted. in_ready=0 after the 8th, full_cnt=2, and out_state holds block 1 stable. Raise out_ready -> block 1, then block 2, each for one cycle. in_ready returns to 1 the cycle after the first read.
- Send 2 words, assert flush 1 cycle while in_valid=1 with 0xDEADBEEF -> fill_cnt=0, 0xDEADBEEF dropped. The next 4 words form a clean block containing no flushed data.
- Assert resetn mid-block (2 words stored) and while a full block is pending -> out_valid=0, full_cnt=0, fill_cnt=0, out_state=0. in_ready=0 during reset and 1 the cycle after.
- Continuous 1 word/cycle for 32 words with random out_ready (≥50% high) -> 8 blocks delivered in order, no word lost or duplicated, out_state stable whenever out_valid && !out_ready.

Source files
------------

// File: rtl/mod_reg16_4to16.sv
// Column-to-state assembler: collects Nb WW-bit words into one Nb*WW block,
// ping-ponging between two buffers so one fills while the other is presented.

module mod_reg16_4to16_bank #(
    parameter int Nb = 4,
    parameter int WW = 32,
    parameter int CW = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [CW-1:0]          wr_col,
    input  logic [WW-1:0]          wr_word,
    input  logic                   clr,
    input  logic                   set_full,
    input  logic                   clr_full,
    output logic [Nb-1:0][WW-1:0]  data,
    output logic                   full
);

    always_ff @(posedge clk) begin
        if (resetn) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (clr)
                data <= '0;
            else if (wr_en)
                data[wr_col] <= wr_word;
            // set and clear never target the same bank in one cycle
            if (set_full)
                full <= 1'b1;
            else if (clr_full)
                full <= 1'b0;
        end
    end

endmodule

module mod_reg16_4to16 #(
    parameter int Nb = 4,
    parameter int WW = 32
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WW-1:0]                          in_word,
    input  logic                                   flush,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [Nb*WW-1:0]                       out_state,
    output logic [((Nb > 1) ? $clog2(Nb) : 1)-1:0] fill_cnt,
    output logic [1:0]                             full_cnt
);

    localparam int CW = (Nb > 1) ? $clog2(Nb) : 1;

    logic                        wptr, rptr;
    logic [CW-1:0]               wcnt;
    logic [1:0]                  bfull;
    logic [1:0][Nb-1:0][WW-1:0]  bank;
    logic                        wr_acc, rd_acc, last_col;

    assign in_ready  = !bfull[wptr] && !flush && !resetn;
    assign wr_acc    = in_valid && in_ready;
    assign out_valid = bfull[rptr];
    assign rd_acc    = out_valid && out_ready;
    assign out_state = bank[rptr];
    assign last_col  = (wcnt == CW'(Nb - 1));
    assign fill_cnt  = wcnt;
    assign full_cnt  = {1'b0, bfull[0]} + {1'b0, bfull[1]};

    always_ff @(posedge clk) begin
        if (resetn) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            wcnt <= '0;
        end else begin
            if (flush)
                wcnt <= '0;
            else if (wr_acc) begin
                if (last_col) begin
                    wcnt <= '0;
                    wptr <= ~wptr;
                end else
                    wcnt <= wcnt + 1'b1;
            end
            if (rd_acc)
                rptr <= ~rptr;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic sel_w, sel_r;
        assign sel_w = (wptr == 1'(b));
        assign sel_r = (rptr == 1'(b));

        // flush only wipes a partially filled bank; wcnt==0 leaves it untouched
        mod_reg16_4to16_bank #(.Nb(Nb), .WW(WW), .CW(CW)) u_bank (
            .clk      (clk),
            .resetn   (resetn),
            .wr_en    (wr_acc && sel_w),
            .wr_col   (wcnt),
            .wr_word  (in_word),
            .clr      (flush && sel_w && (wcnt != '0)),
            .set_full (wr_acc && sel_w && last_col),
            .clr_full (rd_acc && sel_r),
            .data     (bank[b]),
            .full     (bfull[b])
        );
    end

endmodule

// File: tb/tb_mod_reg16_4to16.sv
// Bench for mod_reg16_4to16: directed vector table plus random traffic,
// checked every cycle against a queue-based model of blocks and partial fill.

module tb_mod_reg16_4to16;

    localparam int Nb = 4;
    localparam int WW = 32;
    localparam int SW = Nb * WW;

    typedef logic [SW-1:0] blk_t;

    typedef struct {
        logic        rst, iv, fl, ordy;
        logic [31:0] w;
        logic        e_rdy, e_ov;
        logic [1:0]  e_fc, e_fl;
        logic        chk_st;
        blk_t        e_st;
    } vec_t;

    logic           clk = 1'b0;
    logic           resetn, in_valid, in_ready, flush, out_valid, out_ready;
    logic [WW-1:0]  in_word;
    logic [SW-1:0]  out_state;
    logic [1:0]     fill_cnt, full_cnt;

    mod_reg16_4to16 #(.Nb(Nb), .WW(WW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .fill_cnt  (fill_cnt),
        .full_cnt  (full_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    blk_t        blocks[$];
    logic [WW-1:0] part[$];
    bit          m_wacc, m_racc;
    int          n_racc = 0;
    vec_t        vecs[17];

    task automatic chk(string nm, logic [SW-1:0] act, logic [SW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rst, logic iv, logic fl, logic ordy, logic [31:0] w,
                                logic rdy, logic ov, logic [1:0] fc, logic [1:0] fu,
                                logic cs, blk_t st);
        vec_t v;
        v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy; v.w = w;
        v.e_rdy = rdy; v.e_ov = ov; v.e_fc = fc; v.e_fl = fu; v.chk_st = cs; v.e_st = st;
        return v;
    endfunction

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic step(int vi);
        bit mrdy, mov;
        #1;
        mrdy = !resetn && !flush && (blocks.size() < 2);
        mov  = blocks.size() > 0;
        chk("in_ready", in_ready, mrdy);
        chk("out_valid", out_valid, mov);
        chk("fill_cnt", fill_cnt, part.size());
        chk("full_cnt", full_cnt, blocks.size());
        if (mov) chk("out_state", out_state, blocks[0]);
        if (vi >= 0) begin
            chk($sformatf("vec%0d in_ready", vi), in_ready, vecs[vi].e_rdy);
            chk($sformatf("vec%0d out_valid", vi), out_valid, vecs[vi].e_ov);
            chk($sformatf("vec%0d fill_cnt", vi), fill_cnt, vecs[vi].e_fc);
            chk($sformatf("vec%0d full_cnt", vi), full_cnt, vecs[vi].e_fl);
            if (vecs[vi].chk_st) chk($sformatf("vec%0d out_state", vi), out_state, vecs[vi].e_st);
        end
        m_wacc = in_valid && mrdy;
        m_racc = mov && out_ready && !resetn;
        @(posedge clk);
        if (resetn) begin
            part.delete();
            blocks.delete();
        end else begin
            if (m_racc) void'(blocks.pop_front());
            if (flush) part.delete();
            else if (m_wacc) begin
                part.push_back(in_word);
                if (part.size() == Nb) begin
                    blk_t nb;
                    for (int c = 0; c < Nb; c++) nb[WW*c +: WW] = part[c];
                    blocks.push_back(nb);
                    part.delete();
                end
            end
        end
        if (m_racc) n_racc++;
        #1;
    endtask

    initial begin
        int   acc, r0, cyc;
        blk_t b1, b2;
        b1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        b2 = 128'hA0000003_A0000002_A0000001_A0000000;

        //          rst iv fl or word          rdy ov fc fu cs st
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, '0);
        vecs[1]  = mk(0, 1, 0, 1, 32'h03020100, 1, 0, 0, 0, 0, '0);
        vecs[2]  = mk(0, 1, 0, 1, 32'h07060504, 1, 0, 1, 0, 0, '0);
        vecs[3]  = mk(0, 1, 0, 1, 32'h0B0A0908, 1, 0, 2, 0, 0, '0);
        vecs[4]  = mk(0, 1, 0, 1, 32'h0F0E0D0C, 1, 0, 3, 0, 0, '0);
        vecs[5]  = mk(0, 0, 0, 1, 32'h0,        1, 1, 0, 1, 1, b1);
        vecs[6]  = mk(0, 0, 0, 1, 32'h0,        1, 0, 0, 0, 0, '0);
        vecs[7]  = mk(0, 1, 0, 1, 32'h11111111, 1, 0, 0, 0, 0, '0);
        vecs[8]  = mk(0, 1, 0, 1, 32'h22222222, 1, 0, 1, 0, 0, '0);
        vecs[9]  = mk(0, 1, 1, 1, 32'hDEADBEEF, 0, 0, 2, 0, 0, '0);
        vecs[10] = mk(0, 1, 0, 0, 32'hA0000000, 1, 0, 0, 0, 0, '0);
        vecs[11] = mk(0, 1, 0, 0, 32'hA0000001, 1, 0, 1, 0, 0, '0);
        vecs[12] = mk(0, 1, 0, 0, 32'hA0000002, 1, 0, 2, 0, 0, '0);
        vecs[13] = mk(0, 1, 0, 0, 32'hA0000003, 1, 0, 3, 0, 0, '0);
        vecs[14] = mk(0, 0, 0, 0, 32'h0,        1, 1, 0, 1, 1, b2);
        vecs[15] = mk(0, 0, 0, 1, 32'h0,        1, 1, 0, 1, 1, b2);
        vecs[16] = mk(0, 0, 0, 1, 32'h0,        1, 0, 0, 0, 0, '0);

        resetn = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_word = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            resetn = vecs[i].rst; in_valid = vecs[i].iv; flush = vecs[i].fl;
            out_ready = vecs[i].ordy; in_word = vecs[i].w;
            step(i);
        end

        // backpressure: both buffers fill, then drain
        acc = 0;
        out_ready = 1'b0; in_valid = 1'b1; flush = 1'b0;
        for (int k = 0; k < 12; k++) begin
            in_word = 32'h50000000 + acc;
            step(-1);
            if (m_wacc) acc++;
        end
        chk("bp_accepted", acc, 8);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_full_cnt", full_cnt, 2);
        in_valid = 1'b0; out_ready = 1'b1;
        step(-1);
        chk("bp_ready_after_read", in_ready, 1'b1);
        step(-1);
        step(-1);
        chk("bp_drained", full_cnt, 0);

        // reset with a full block pending and a partial block in progress
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_word = 32'h60000000 + k;
            step(-1);
        end
        resetn = 1'b1;
        step(-1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_full_cnt", full_cnt, 0);
        chk("rst_fill_cnt", fill_cnt, 0);
        chk("rst_out_state", out_state, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        resetn = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_release_ready", in_ready, 1'b1);
        step(-1);

        // random traffic: 32 words with random consumer backpressure
        acc = 0; r0 = n_racc; cyc = 0;
        in_valid = 1'b1;
        in_word = $urandom;
        while (cyc < 400 && (acc < 32 || blocks.size() > 0)) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step(-1);
            cyc++;
            if (m_wacc) begin
                acc++;
                in_word = $urandom;
            end
            if (acc >= 32) in_valid = 1'b0;
        end
        chk("rand_in_time", cyc < 400, 1'b1);
        chk("rand_words", acc, 32);
        chk("rand_blocks", n_racc - r0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
